// File: rtl/bec_trace.sv
// Capture stage for the bec controller's 39-bit output vector.
// Optional MISR signature: define BEC_TRACE_MISR_EN.
module bec_trace #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [38:0]     y_in,
  input  logic            y_sample,
  input  logic            clr,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [38:0]     rd_data,
  output logic [TS_W-1:0] rd_ts,
  output logic            ovf,
  output logic [15:0]     evt_cnt,
  output logic [7:0]      drop_cnt,
  output logic [38:0]     sig
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [38:0]      mem_y  [DEPTH];
  logic [TS_W-1:0]  mem_ts [DEPTH];
  logic [38:0]      last_y;
  logic [TS_W-1:0]  last_ts;
  logic [TS_W-1:0]  ts;
  logic             empty;
  logic             full;
  logic             hit;
  logic             pop;
  logic             push;
  logic             drop;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_idx == rd_idx);

  assign hit  = y_sample && (|y_in);
  assign pop  = !empty && rd_ready;
  // A pop frees a slot in the same cycle, so full+pop never drops.
  assign push = hit && (!full || pop);
  assign drop = hit && full && !pop;

  assign rd_valid = !empty;
  assign rd_data  = empty ? last_y  : mem_y[rd_idx];
  assign rd_ts    = empty ? last_ts : mem_ts[rd_idx];

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_y[wr_idx]  <= y_in;
      mem_ts[wr_idx] <= ts;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_y   <= '0;
      last_ts  <= '0;
      ts       <= '0;
      ovf      <= 1'b0;
      evt_cnt  <= '0;
      drop_cnt <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_y   <= '0;
      last_ts  <= '0;
      ts       <= '0;
      ovf      <= 1'b0;
      evt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        last_y  <= mem_y[rd_idx];
        last_ts <= mem_ts[rd_idx];
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (evt_cnt != 16'hFFFF)
          evt_cnt <= evt_cnt + 16'd1;
      end
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

`ifdef BEC_TRACE_MISR_EN
  logic [38:0] misr;

  // x^39 + x^4 + 1, zero vectors still fold in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misr <= '0;
    end else if (clr) begin
      misr <= '0;
    end else if (y_sample) begin
      misr <= ({misr[37:0], 1'b0} ^
               (misr[38] ? 39'h11 : 39'h0)) ^ y_in;
    end
  end

  assign sig = misr;
`else
  assign sig = 39'h0;
`endif

endmodule

// File: tb/tb_bec_trace.sv
// Self-checking bench for bec_trace against a queue-based model.
// Second instance with TS_W=4 covers timestamp wrap.
module tb_bec_trace;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic [38:0] y_in;
  logic        y_sample;
  logic        clr;
  logic        rd_ready;

  logic        rd_valid;
  logic [38:0] rd_data;
  logic [15:0] rd_ts;
  logic        ovf;
  logic [15:0] evt_cnt;
  logic [7:0]  drop_cnt;
  logic [38:0] sig;

  logic        rd_valid_w;
  logic [38:0] rd_data_w;
  logic [3:0]  rd_ts_w;
  logic        ovf_w;
  logic [15:0] evt_cnt_w;
  logic [7:0]  drop_cnt_w;
  logic [38:0] sig_w;

  int n_cmp;
  int n_bad;

  bec_trace #(.DEPTH(DEPTH), .TS_W(16)) u_dut (
    .clk(clk), .rst(rst), .y_in(y_in),
    .y_sample(y_sample), .clr(clr),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_ts(rd_ts), .ovf(ovf),
    .evt_cnt(evt_cnt), .drop_cnt(drop_cnt), .sig(sig)
  );

  bec_trace #(.DEPTH(DEPTH), .TS_W(4)) u_w (
    .clk(clk), .rst(rst), .y_in(y_in),
    .y_sample(y_sample), .clr(clr),
    .rd_valid(rd_valid_w), .rd_ready(rd_ready),
    .rd_data(rd_data_w), .rd_ts(rd_ts_w), .ovf(ovf_w),
    .evt_cnt(evt_cnt_w), .drop_cnt(drop_cnt_w),
    .sig(sig_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [38:0] y;
    int          ts;
  } ent_t;

  ent_t        q[$];
  int          mts;
  logic [38:0] last_y;
  int          last_ts;
  logic        movf;
  int          mevt;
  int          mdrop;
  logic [38:0] msig;

  function automatic logic [38:0] misr_next(
    input logic [38:0] s, input logic [38:0] d);
    logic carry;
    carry = s[38];
    s = s << 1;
    if (carry) s = s ^ 39'h11;
    return s ^ d;
  endfunction

  task automatic model_reset();
    q.delete();
    mts = 0;
    last_y = '0;
    last_ts = 0;
    movf = 1'b0;
    mevt = 0;
    mdrop = 0;
    msig = '0;
  endtask

  task automatic model_step();
    bit   pop;
    bit   ev;
    bit   was_full;
    ent_t e;
    if (!rst || clr) begin
      model_reset();
      return;
    end
    pop = (q.size() > 0) && rd_ready;
    ev = y_sample && (y_in != 39'h0);
    was_full = (q.size() == DEPTH);
    if (y_sample) msig = misr_next(msig, y_in);
    if (pop) begin
      last_y = q[0].y;
      last_ts = q[0].ts;
      void'(q.pop_front());
    end
    if (ev) begin
      if (!was_full || pop) begin
        e.y = y_in;
        e.ts = mts;
        q.push_back(e);
        if (mevt < 65535) mevt++;
      end else begin
        movf = 1'b1;
        if (mdrop < 255) mdrop++;
      end
    end
    mts++;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic        ev;
    logic [38:0] ey;
    int          et;
    logic [38:0] es;
    ev = (q.size() != 0);
    ey = ev ? q[0].y : last_y;
    et = ev ? q[0].ts : last_ts;
`ifdef BEC_TRACE_MISR_EN
    es = msig;
`else
    es = 39'h0;
`endif
    chk("rd_valid", 64'(rd_valid), 64'(ev));
    chk("rd_data", 64'(rd_data), 64'(ey));
    chk("rd_ts", 64'(rd_ts), 64'(et & 'hFFFF));
    chk("ovf", 64'(ovf), 64'(movf));
    chk("evt_cnt", 64'(evt_cnt), 64'(mevt));
    chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    chk("sig", 64'(sig), 64'(es));
    chk("w_valid", 64'(rd_valid_w), 64'(ev));
    chk("w_data", 64'(rd_data_w), 64'(ey));
    chk("w_ts", 64'(rd_ts_w), 64'(et & 'hF));
    chk("w_evt", 64'(evt_cnt_w), 64'(mevt));
    chk("w_drop", 64'(drop_cnt_w), 64'(mdrop));
    chk("w_ovf", 64'(ovf_w), 64'(movf));
    chk("w_sig", 64'(sig_w), 64'(es));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic s, input logic [38:0] y,
                       input logic r);
    y_sample = s;
    y_in = y;
    rd_ready = r;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    drive(1'b0, 39'h0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [38:0] ry;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    clr = 1'b0;
    drive(1'b0, 39'h0, 1'b0);
    model_reset();
    #1;

    // reset held with zero samples
    drive(1'b1, 39'h0, 1'b0);
    for (int i = 0; i < 10; i++) step();

    // single event on 6th edge after release
    rst = 1'b1;
    idle(5);
    drive(1'b1, 39'h0C, 1'b0);
    step();
    chk("tp_ts5", 64'(rd_ts), 64'd5);
    drive(1'b0, 39'h0, 1'b1);
    step();
    chk("tp_pop", 64'(rd_valid), 64'd0);

    // overflow: 10 events into 8 entries
    drive(1'b0, 39'h0, 1'b0);
    do_reset();
    step();
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 39'(i), 1'b0);
      step();
    end
    chk("tp_drop2", 64'(drop_cnt), 64'd2);
    chk("tp_evt8", 64'(evt_cnt), 64'd8);
    drive(1'b0, 39'h0, 1'b1);
    for (int i = 0; i < 8; i++) step();

    // full + push + pop in the same cycle
    drive(1'b0, 39'h0, 1'b0);
    do_reset();
    step();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 39'(i + 21), 1'b0);
      step();
    end
    drive(1'b1, 39'h4_0000_0000, 1'b1);
    step();
    chk("tp_noovf", 64'(ovf), 64'd0);
    drive(1'b0, 39'h0, 1'b1);
    for (int i = 0; i < 8; i++) step();
    chk("tp_last", 64'(rd_data), 64'h4_0000_0000);

    // MISR 1 then 0, then clr
    drive(1'b0, 39'h0, 1'b0);
    do_reset();
    step();
    rst = 1'b1;
    drive(1'b1, 39'h1, 1'b0);
    step();
    drive(1'b1, 39'h0, 1'b0);
    step();
    clr = 1'b1;
    drive(1'b1, 39'h7, 1'b1);
    step();
    clr = 1'b0;
    drive(1'b0, 39'h0, 1'b0);
    step();

    // ts wrap on the 4-bit instance: event at 17th edge
    do_reset();
    rst = 1'b1;
    idle(16);
    drive(1'b1, 39'h55, 1'b0);
    step();
    chk("tp_wrap", 64'(rd_ts_w), 64'd0);

    // drop counter saturation
    for (int i = 0; i < 270; i++) begin
      drive(1'b1, 39'(i + 1), 1'b0);
      step();
    end

    // reset mid-operation empties the FIFO at once
    do_reset();
    drive(1'b0, 39'h0, 1'b0);
    step();
    rst = 1'b1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      ry = {$urandom, $urandom};
      if ($urandom_range(3) == 0) ry = 39'h0;
      drive(1'($urandom_range(1)), ry,
            1'($urandom_range(2) != 0));
      clr = ($urandom_range(60) == 0);
      step();
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
